// File: rtl/crc_pkg.sv
// Shared definitions for the CRC stream engine family.
//   state_t     : frame FSM states (IDLE, RUN, DONE)
//   CRC*_xxx    : polynomial / init / final-XOR presets for common CRCs
//   bit_reverse : reverses the low 'width' bits of a 32-bit value
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0]  CRC8_POLY              = 8'h07;
  localparam logic [7:0]  CRC8_INIT              = 8'h00;
  localparam logic [7:0]  CRC8_XOR_OUT           = 8'h00;

  localparam logic [15:0] CRC16_CCITT_FALSE_POLY    = 16'h1021;
  localparam logic [15:0] CRC16_CCITT_FALSE_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC16_CCITT_FALSE_XOR_OUT = 16'h0000;

  localparam logic [31:0] CRC32_POLY             = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT             = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOR_OUT          = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE          = 32'hC704DD7B;
  localparam bit          CRC32_REFLECT          = 1'b1;

  // Reverse all 32 bits, then drop the (32 - width) bits that came from
  // the unused upper part; value must be zero above bit width-1.
  function automatic logic [31:0] bit_reverse(input logic [31:0] value,
                                              input int unsigned width);
    logic [31:0] r;
    for (int unsigned i = 0; i < 32; i++) begin
      r[i] = value[31-i];
    end
    return r >> (32 - width);
  endfunction

endpackage

// File: rtl/crc_fold.sv
// Combinational CRC fold: next register value after shifting DATA_WIDTH
// data bits through the CRC register.
//   i_crc  : current register (reflected domain when REFLECT_IN=1)
//   i_data : data word; MSB first, or LSB first when REFLECT_IN=1
//   o_crc  : register after all DATA_WIDTH bits
module crc_fold
  import crc_pkg::*;
#(
  parameter int unsigned           CRC_WIDTH  = 8,
  parameter logic [CRC_WIDTH-1:0]  POLY       = 8'h07,
  parameter int unsigned           DATA_WIDTH = 8,
  parameter bit                    REFLECT_IN = 1'b0
) (
  input  logic [CRC_WIDTH-1:0]  i_crc,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [CRC_WIDTH-1:0]  o_crc
);

  localparam logic [CRC_WIDTH-1:0] POLY_REFL =
    CRC_WIDTH'(bit_reverse(32'(POLY), CRC_WIDTH));

  always_comb begin
    logic [CRC_WIDTH-1:0] acc;
    logic                 fb;
    acc = i_crc;
    fb  = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (REFLECT_IN) begin
        // Reflected register: LSB is the oldest bit, shift right.
        fb  = acc[0] ^ i_data[i];
        acc = (acc >> 1) ^ (fb ? POLY_REFL : '0);
      end else begin
        fb  = acc[CRC_WIDTH-1] ^ i_data[DATA_WIDTH-1-i];
        acc = (acc << 1) ^ (fb ? POLY : '0);
      end
    end
    o_crc = acc;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC generator/checker, one DATA_WIDTH beat per cycle.
//   clock, reset (async, active-high), clear (sync frame abort)
//   data_in/data_valid/data_last/data_ready : beat handshake
//   crc_out   : final CRC of the latest frame (held)
//   crc_valid : one-cycle pulse in DONE
//   crc_match : raw register equals RESIDUE in DONE
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int unsigned          CRC_WIDTH   = 8,
  parameter logic [CRC_WIDTH-1:0] POLY        = 8'h07,
  parameter logic [CRC_WIDTH-1:0] INIT        = '0,
  parameter logic [CRC_WIDTH-1:0] XOR_OUT     = '0,
  parameter int unsigned          DATA_WIDTH  = 8,
  parameter bit                   REFLECT_IN  = 1'b0,
  parameter bit                   REFLECT_OUT = 1'b0,
  parameter logic [CRC_WIDTH-1:0] RESIDUE     = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  input  logic                  data_last,
  output logic                  data_ready,
  output logic [CRC_WIDTH-1:0]  crc_out,
  output logic                  crc_valid,
  output logic                  crc_match
);

  function automatic logic [CRC_WIDTH-1:0] rev(input logic [CRC_WIDTH-1:0] v);
    return CRC_WIDTH'(bit_reverse(32'(v), CRC_WIDTH));
  endfunction

  // The register lives in the reflected domain when REFLECT_IN=1; this
  // maps it back to the standard (unreflected) CRC register view.
  function automatic logic [CRC_WIDTH-1:0] std_view(input logic [CRC_WIDTH-1:0] r);
    return REFLECT_IN ? rev(r) : r;
  endfunction

  function automatic logic [CRC_WIDTH-1:0] final_crc(input logic [CRC_WIDTH-1:0] s);
    return (REFLECT_OUT ? rev(s) : s) ^ XOR_OUT;
  endfunction

  localparam logic [CRC_WIDTH-1:0] INIT_REG = REFLECT_IN ? rev(INIT) : INIT;

  state_t                r_state;
  state_t                w_state_next;
  logic [CRC_WIDTH-1:0]  r_crc;
  logic [CRC_WIDTH-1:0]  r_crc_out;
  logic [CRC_WIDTH-1:0]  w_fold;
  logic                  w_accept;

  crc_fold #(
    .CRC_WIDTH  (CRC_WIDTH),
    .POLY       (POLY),
    .DATA_WIDTH (DATA_WIDTH),
    .REFLECT_IN (REFLECT_IN)
  ) u_fold (
    .i_crc  (r_crc),
    .i_data (data_in),
    .o_crc  (w_fold)
  );

  // clear wins over a simultaneous beat.
  assign w_accept = data_valid & data_ready & ~clear;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE, RUN: if (w_accept) w_state_next = data_last ? DONE : RUN;
        DONE:      w_state_next = IDLE;
        default:   w_state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    data_ready = (r_state != DONE);
    crc_valid  = (r_state == DONE) & ~clear;
    crc_match  = crc_valid & (std_view(r_crc) == RESIDUE);
  end

  // crc_out is captured on the last-beat edge so it is already valid
  // during DONE, matching the register held there.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_crc     <= INIT_REG;
      r_crc_out <= final_crc(INIT);
    end else begin
      if (clear || r_state == DONE) begin
        r_crc <= INIT_REG;
      end else if (w_accept) begin
        r_crc <= w_fold;
      end
      if (w_accept && data_last) begin
        r_crc_out <= final_crc(std_view(w_fold));
      end
    end
  end

  assign crc_out = r_crc_out;

endmodule

// File: tb/tb_crc_stream_engine.sv
module tb_crc_stream_engine;
  import crc_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, clear;
  logic [7:0]  d;
  logic        v, l;
  logic [15:0] dw;
  logic        vw, lw;

  logic        rdy8, vld8, m8;
  logic [7:0]  c8;
  logic        rdy16, vld16, m16;
  logic [15:0] c16;
  logic        rdy32, vld32, m32;
  logic [31:0] c32;
  logic        rdyw, vldw, mw;
  logic [7:0]  cw;

  int errors = 0;
  int checks = 0;

  crc_stream_engine u8 (
    .clock(clock), .reset(reset), .clear(clear), .data_in(d), .data_valid(v),
    .data_last(l), .data_ready(rdy8), .crc_out(c8), .crc_valid(vld8), .crc_match(m8)
  );

  crc_stream_engine #(
    .CRC_WIDTH(16), .POLY(CRC16_CCITT_FALSE_POLY), .INIT(CRC16_CCITT_FALSE_INIT),
    .XOR_OUT(CRC16_CCITT_FALSE_XOR_OUT), .DATA_WIDTH(8)
  ) u16 (
    .clock(clock), .reset(reset), .clear(clear), .data_in(d), .data_valid(v),
    .data_last(l), .data_ready(rdy16), .crc_out(c16), .crc_valid(vld16), .crc_match(m16)
  );

  crc_stream_engine #(
    .CRC_WIDTH(32), .POLY(CRC32_POLY), .INIT(CRC32_INIT), .XOR_OUT(CRC32_XOR_OUT),
    .DATA_WIDTH(8), .REFLECT_IN(CRC32_REFLECT), .REFLECT_OUT(CRC32_REFLECT),
    .RESIDUE(CRC32_RESIDUE)
  ) u32 (
    .clock(clock), .reset(reset), .clear(clear), .data_in(d), .data_valid(v),
    .data_last(l), .data_ready(rdy32), .crc_out(c32), .crc_valid(vld32), .crc_match(m32)
  );

  crc_stream_engine #(
    .CRC_WIDTH(8), .POLY(CRC8_POLY), .DATA_WIDTH(16)
  ) uw (
    .clock(clock), .reset(reset), .clear(clear), .data_in(dw), .data_valid(vw),
    .data_last(lw), .data_ready(rdyw), .crc_out(cw), .crc_valid(vldw), .crc_match(mw)
  );

  typedef struct {
    logic [7:0]  d;
    logic        v, l, c;
    logic        rdy, vld;
    logic [7:0]  crc;
    logic        m;
    logic        wide;
    logic [15:0] crc16;
    logic [31:0] crc32;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] d_, input logic v_, input logic l_, input logic c_,
                     input logic rdy_, input logic vld_, input logic [7:0] crc_, input logic m_);
    vec_t r;
    r = '{default: '0};
    r.d = d_; r.v = v_; r.l = l_; r.c = c_;
    r.rdy = rdy_; r.vld = vld_; r.crc = crc_; r.m = m_;
    tbl.push_back(r);
  endtask

  task automatic send_check_line(input string tag);
    // nine bytes "123456789", then the DONE cycle
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      d = 8'h31 + 8'(i); v = 1'b1; l = (i == 8);
    end
    @(negedge clock);
    v = 1'b0; l = 1'b0;
    #1;
    chk({tag, "_vld8"}, 32'(vld8), 32'd1);
    chk({tag, "_c8"}, 32'(c8), 32'hF4);
    chk({tag, "_c16"}, 32'(c16), 32'h29B1);
    chk({tag, "_c32"}, c32, 32'hCBF43926);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] res_bytes [13];
    reset = 1'b1; clear = 1'b0; d = '0; v = 1'b0; l = 1'b0;
    dw = '0; vw = 1'b0; lw = 1'b0;

    // frame "123456789"
    for (int i = 0; i < 9; i++) add(8'h31 + 8'(i), 1, i == 8, 0, 1, 0, 8'h00, 0);
    add(8'h00, 0, 0, 0, 0, 1, 8'hF4, 0);
    tbl[tbl.size()-1].wide  = 1'b1;
    tbl[tbl.size()-1].crc16 = 16'h29B1;
    tbl[tbl.size()-1].crc32 = 32'hCBF43926;
    add(8'h00, 0, 1, 0, 1, 0, 8'hF4, 0);   // data_last without data_valid
    add(8'h00, 0, 1, 0, 1, 0, 8'hF4, 0);
    // 01,07 -> CRC 00, residue match
    add(8'h01, 1, 0, 0, 1, 0, 8'hF4, 0);
    add(8'h07, 1, 1, 0, 1, 0, 8'hF4, 0);
    add(8'h00, 0, 0, 0, 0, 1, 8'h00, 1);
    // 01,08 -> CRC 2D, no match
    add(8'h01, 1, 0, 0, 1, 0, 8'h00, 0);
    add(8'h08, 1, 1, 0, 1, 0, 8'h00, 0);
    add(8'h00, 0, 0, 0, 0, 1, 8'h2D, 0);
    // back-to-back single-beat frames with valid held high
    add(8'h01, 1, 1, 0, 1, 0, 8'h2D, 0);
    add(8'h01, 1, 1, 0, 0, 1, 8'h07, 0);
    add(8'h01, 1, 1, 0, 1, 0, 8'h07, 0);
    add(8'h01, 1, 1, 0, 0, 1, 8'h07, 0);
    add(8'h00, 0, 0, 0, 1, 0, 8'h07, 0);
    // clear together with a last beat: dropped, no pulse
    add(8'h31, 1, 0, 0, 1, 0, 8'h07, 0);
    add(8'h32, 1, 0, 0, 1, 0, 8'h07, 0);
    add(8'h33, 1, 1, 1, 1, 0, 8'h07, 0);
    add(8'h00, 0, 0, 0, 1, 0, 8'h07, 0);
    add(8'h01, 1, 1, 0, 1, 0, 8'h07, 0);
    add(8'h00, 0, 0, 0, 0, 1, 8'h07, 0);
    // clear in DONE suppresses valid and match; crc_out still updates
    add(8'h01, 1, 0, 0, 1, 0, 8'h07, 0);
    add(8'h07, 1, 1, 0, 1, 0, 8'h07, 0);
    add(8'h00, 0, 0, 1, 0, 0, 8'h00, 0);
    add(8'h00, 0, 0, 0, 1, 0, 8'h00, 0);
    add(8'h01, 1, 1, 0, 1, 0, 8'h00, 0);
    add(8'h00, 0, 0, 0, 0, 1, 8'h07, 0);
    add(8'h00, 0, 0, 0, 1, 0, 8'h07, 0);

    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_rdy8", 32'(rdy8), 32'd1);
    chk("rst_vld8", 32'(vld8), 32'd0);
    chk("rst_m8", 32'(m8), 32'd0);
    chk("rst_c8", 32'(c8), 32'h00);
    chk("rst_c16", 32'(c16), 32'hFFFF);
    chk("rst_c32", c32, 32'h0);
    chk("rst_cw", 32'(cw), 32'h00);

    foreach (tbl[k]) begin
      @(negedge clock);
      d = tbl[k].d; v = tbl[k].v; l = tbl[k].l; clear = tbl[k].c;
      #1;
      chk($sformatf("row%0d_rdy", k), 32'(rdy8), 32'(tbl[k].rdy));
      chk($sformatf("row%0d_vld", k), 32'(vld8), 32'(tbl[k].vld));
      chk($sformatf("row%0d_crc", k), 32'(c8), 32'(tbl[k].crc));
      chk($sformatf("row%0d_match", k), 32'(m8), 32'(tbl[k].m));
      if (tbl[k].wide) begin
        chk($sformatf("row%0d_vld16", k), 32'(vld16), 32'd1);
        chk($sformatf("row%0d_crc16", k), 32'(c16), 32'(tbl[k].crc16));
        chk($sformatf("row%0d_vld32", k), 32'(vld32), 32'd1);
        chk($sformatf("row%0d_crc32", k), c32, tbl[k].crc32);
      end
    end
    @(negedge clock);
    v = 1'b0; l = 1'b0; clear = 1'b0;

    // 16-bit data word 0x0100 in one beat
    @(negedge clock);
    dw = 16'h0100; vw = 1'b1; lw = 1'b1;
    #1;
    chk("w16_rdy", 32'(rdyw), 32'd1);
    @(negedge clock);
    vw = 1'b0; lw = 1'b0;
    #1;
    chk("w16_vld", 32'(vldw), 32'd1);
    chk("w16_crc", 32'(cw), 32'h15);
    chk("w16_rdy_done", 32'(rdyw), 32'd0);
    @(negedge clock);
    #1;
    chk("w16_vld_after", 32'(vldw), 32'd0);

    // asynchronous reset mid-frame, between edges
    @(negedge clock);
    d = 8'h31; v = 1'b1; l = 1'b0;
    @(posedge clock);
    #1 v = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_vld8", 32'(vld8), 32'd0);
    chk("arst_c8", 32'(c8), 32'h00);
    chk("arst_m8", 32'(m8), 32'd0);
    chk("arst_c16", 32'(c16), 32'hFFFF);
    chk("arst_c32", c32, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("arst_rdy8", 32'(rdy8), 32'd1);
    send_check_line("post_rst");

    // CRC-32 frame with its CRC appended LSB-first lands on the residue
    res_bytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                  8'h26, 8'h39, 8'hF4, 8'hCB};
    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      d = res_bytes[i]; v = 1'b1; l = (i == 12);
    end
    @(negedge clock);
    v = 1'b0; l = 1'b0;
    #1;
    chk("res32_vld", 32'(vld32), 32'd1);
    chk("res32_match", 32'(m32), 32'd1);
    chk("res32_crc", c32, 32'h2144DF1C);
    @(negedge clock);
    #1;
    chk("res32_vld_after", 32'(vld32), 32'd0);
    chk("res32_match_after", 32'(m32), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
